// File: rtl/serial_add_sub_pkg.sv
// Shared definitions for the bit-serial adder/subtractor: default datapath
// width and the controller state encoding.
package serial_add_sub_pkg;

    localparam int DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

endpackage

// File: rtl/serial_add_sub_full_adder.sv
// Single-bit full adder cell; the only arithmetic element of the serial datapath.
module serial_add_sub_full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_add_sub.sv
// Bit-serial WIDTH-bit adder/subtractor: one operand bit per clock, LSB first,
// through a single full adder with a registered carry. START/BUSY/DONE handshake.
module serial_add_sub
    import serial_add_sub_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic             SnA,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] R,
    output logic             CO,
    output logic             V,
    output logic             BUSY,
    output logic             DONE
);

    localparam int                CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] sum_sr;
    logic             carry;
    logic [CNT_W-1:0] count;
    logic             fa_s;
    logic             fa_co;

    serial_add_sub_full_adder u_fa (
        .a  (op_a[0]),
        .b  (op_b[0]),
        .ci (carry),
        .s  (fa_s),
        .co (fa_co)
    );

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state  <= ST_IDLE;
            op_a   <= '0;
            op_b   <= '0;
            sum_sr <= '0;
            carry  <= 1'b0;
            count  <= '0;
            R      <= '0;
            CO     <= 1'b0;
            V      <= 1'b0;
            BUSY   <= 1'b0;
            DONE   <= 1'b0;
        end else begin
            DONE <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (START) begin
                        // Subtraction is A + ~B + 1: invert B and seed the carry.
                        op_a  <= A;
                        op_b  <= SnA ? ~B : B;
                        carry <= SnA;
                        count <= '0;
                        BUSY  <= 1'b1;
                        state <= ST_RUN;
                    end else begin
                        state <= ST_IDLE;
                    end
                end

                ST_RUN: begin
                    op_a   <= op_a >> 1;
                    op_b   <= op_b >> 1;
                    carry  <= fa_co;
                    sum_sr <= {fa_s, sum_sr[WIDTH-1:1]};
                    if (count == LAST_BIT) begin
                        // Here carry is the carry into the MSB, fa_co the carry out.
                        R     <= {fa_s, sum_sr[WIDTH-1:1]};
                        CO    <= fa_co;
                        V     <= carry ^ fa_co;
                        BUSY  <= 1'b0;
                        DONE  <= 1'b1;
                        state <= ST_DONE;
                    end else begin
                        count <= count + 1'b1;
                    end
                end

                default: begin
                    BUSY  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
